// File: rtl/return_address_stack_pkg.sv
// Shared defaults and the request encoding for the return address stack.
package return_address_stack_pkg;

  localparam int RAS_ADDR_W = 16;
  localparam int RAS_DEPTH  = 8;

  // Encoded directly from {Push, Pop}.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

endpackage

// File: rtl/return_address_stack_regfile.sv
// DEPTH x SIZE entry storage: one synchronous write port, one asynchronous read port.
module stack_regfile #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            Clock,
  input  logic            WrEn,
  input  logic [AW-1:0]   WrAddr,
  input  logic [SIZE-1:0] WrData,
  input  logic [AW-1:0]   RdAddr,
  output logic [SIZE-1:0] RdData
);

  logic [SIZE-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the stack pointer alone defines which entries are valid.
  always_ff @(posedge Clock) begin
    if (WrEn) mem[WrAddr] <= WrData;
  end

  assign RdData = mem[RdAddr];

endmodule

// File: rtl/return_address_stack.sv
// Return address stack: pointer, sticky error flags, registered Top and request decode.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int SIZE  = RAS_ADDR_W,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic [SIZE-1:0]            PushData,
  output logic [SIZE-1:0]            Top,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  output logic                       Full,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  op_e             op;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE-1:0] top_q, top_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            empty, full;
  logic            wr_en;
  logic [PW-1:0]   wr_addr, rd_addr;
  logic [SIZE-1:0] rd_data;

  assign op    = op_e'({Push, Pop});
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // The entry that becomes Top after a pop; only consumed when Count >= 2.
  assign rd_addr = PW'(count_q - CW'(2));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = PW'(count_q);
    unique case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
          top_d   = PushData;
        end
      end
      OP_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
          top_d   = (count_q >= CW'(2)) ? rd_data : '0;
        end
      end
      OP_REPLACE: begin
        wr_en = 1'b1;
        top_d = PushData;
        if (empty) begin
          // Push half succeeds into entry 0; pop half is rejected.
          wr_addr = '0;
          count_d = CW'(1);
          unf_d   = 1'b1;
        end else begin
          wr_addr = PW'(count_q - CW'(1));
        end
      end
      default: ;
    endcase
    if (Reset) wr_en = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_regfile #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_regfile (
    .Clock  (Clock),
    .WrEn   (wr_en),
    .WrAddr (wr_addr),
    .WrData (PushData),
    .RdAddr (rd_addr),
    .RdData (rd_data)
  );

  assign Top       = top_q;
  assign Count     = count_q;
  assign Empty     = empty;
  assign Full      = full;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based stack model.
module tb_return_address_stack;

  localparam int SIZE  = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            Clock = 1'b0;
  logic            Reset, Push, Pop;
  logic [SIZE-1:0] PushData;
  logic [SIZE-1:0] Top;
  logic [CW-1:0]   Count;
  logic            Empty, Full, Overflow, Underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain LIFO queue plus two sticky bits.
  logic [SIZE-1:0] q[$];
  logic            m_ovf, m_unf;

  always #5 Clock = ~Clock;

  return_address_stack #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Push      (Push),
    .Pop       (Pop),
    .PushData  (PushData),
    .Top       (Top),
    .Count     (Count),
    .Empty     (Empty),
    .Full      (Full),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  function automatic logic [SIZE-1:0] m_top();
    return (q.size() > 0) ? q[q.size()-1] : '0;
  endfunction

  // One clock of stimulus; the model follows the stack rules, and outputs are stable #1 after the edge.
  task automatic cycle(input logic push, input logic pop, input logic [SIZE-1:0] data,
                       input logic rst);
    @(negedge Clock);
    Push = push; Pop = pop; PushData = data; Reset = rst;
    @(posedge Clock);
    #1;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (push && pop) begin
      if (q.size() > 0) q[q.size()-1] = data;
      else begin q.push_back(data); m_unf = 1'b1; end
    end else if (push) begin
      if (q.size() < DEPTH) q.push_back(data);
      else m_ovf = 1'b1;
    end else if (pop) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1'b1;
    end
    Push = 1'b0; Pop = 1'b0; Reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 0, '0, 1);
    repeat (3) cycle(0, 0, '0, 0);
    checks++;
    if ({Top, Count, Empty, Full, Overflow, Underflow} !== {16'h0000, 4'd0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_state: top=%h count=%0d e/f/o/u=%b%b%b%b, want 0000 0 1000",
               Top, Count, Empty, Full, Overflow, Underflow);
    end
  endtask

  task automatic test_push_pop();
    logic [SIZE-1:0] want [3] = '{16'h0020, 16'h0010, 16'h0000};
    cycle(1, 0, 16'h0010, 0);
    cycle(1, 0, 16'h0020, 0);
    cycle(1, 0, 16'h0030, 0);
    checks++;
    if (Top !== 16'h0030 || Count !== 4'd3) begin
      errors++;
      $display("FAIL push3: top=%h count=%0d, want 0030 3", Top, Count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, '0, 0);
      checks++;
      if (Top !== want[i] || Count !== CW'(2 - i)) begin
        errors++;
        $display("FAIL pop%0d: top=%h count=%0d, want %h %0d", i, Top, Count, want[i], 2 - i);
      end
    end
    checks++;
    if (Empty !== 1'b1 || Underflow !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty: empty=%b underflow=%b, want 1 0", Empty, Underflow);
    end
  endtask

  task automatic test_overflow();
    cycle(0, 0, '0, 1);
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, SIZE'(2 * i), 0);
    checks++;
    if (Full !== 1'b1 || Top !== 16'h0010 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b top=%h ovf=%b, want 1 0010 0", Full, Top, Overflow);
    end
    cycle(1, 0, 16'hFFFF, 0);
    checks++;
    if (Overflow !== 1'b1 || Top !== 16'h0010 || Count !== 4'd8) begin
      errors++;
      $display("FAIL overflow: ovf=%b top=%h count=%0d, want 1 0010 8", Overflow, Top, Count);
    end
    cycle(1, 1, 16'h1234, 0);
    checks++;
    if (Top !== 16'h1234 || Count !== 4'd8 || Full !== 1'b1 || Overflow !== 1'b1) begin
      errors++;
      $display("FAIL replace_full: top=%h count=%0d full=%b ovf=%b, want 1234 8 1 1",
               Top, Count, Full, Overflow);
    end
    cycle(0, 1, '0, 0);
    checks++;
    if (Top !== 16'h000E || Count !== 4'd7) begin
      errors++;
      $display("FAIL pop_after_full: top=%h count=%0d, want 000e 7", Top, Count);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, '0, 1);
    cycle(0, 1, '0, 0);
    checks++;
    if (Underflow !== 1'b1 || Count !== 4'd0 || Top !== 16'h0000) begin
      errors++;
      $display("FAIL underflow: unf=%b count=%0d top=%h, want 1 0 0000", Underflow, Count, Top);
    end
    cycle(1, 1, 16'h00AA, 0);
    checks++;
    if (Count !== 4'd1 || Top !== 16'h00AA || Underflow !== 1'b1) begin
      errors++;
      $display("FAIL replace_empty: count=%0d top=%h unf=%b, want 1 00aa 1", Count, Top, Underflow);
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, '0, 1);
    cycle(0, 1, '0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, SIZE'(16'h0500 + i), 0);
    cycle(1, 0, 16'h0999, 1);
    checks++;
    if ({Top, Count, Empty, Full, Overflow, Underflow} !== {16'h0000, 4'd0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_with_push: top=%h count=%0d e/f/o/u=%b%b%b%b, want 0000 0 1000",
               Top, Count, Empty, Full, Overflow, Underflow);
    end
    cycle(1, 0, 16'h0042, 0);
    checks++;
    if (Count !== 4'd1 || Top !== 16'h0042) begin
      errors++;
      $display("FAIL push_after_reset: count=%0d top=%h, want 1 0042", Count, Top);
    end
  endtask

  task automatic test_replace();
    cycle(0, 0, '0, 1);
    cycle(1, 0, 16'h0100, 0);
    cycle(1, 0, 16'h0200, 0);
    cycle(1, 1, 16'h0300, 0);
    checks++;
    if (Count !== 4'd2 || Top !== 16'h0300) begin
      errors++;
      $display("FAIL replace: count=%0d top=%h, want 2 0300", Count, Top);
    end
    cycle(0, 1, '0, 0);
    checks++;
    if (Top !== 16'h0100 || Count !== 4'd1) begin
      errors++;
      $display("FAIL pop_after_replace: top=%h count=%0d, want 0100 1", Top, Count);
    end
  endtask

  task automatic test_random();
    logic            push, pop, rst;
    logic [SIZE-1:0] data;
    cycle(0, 0, '0, 1);
    for (int n = 0; n < 600; n++) begin
      // Bias toward pushes early in each run of 100 and pops later, to reach both ends.
      push = ($urandom_range(99) < ((n % 100) < 50 ? 70 : 30));
      pop  = ($urandom_range(99) < ((n % 100) < 50 ? 30 : 70));
      rst  = ($urandom_range(59) == 0);
      data = SIZE'($urandom);
      cycle(push, pop, data, rst);
      checks++;
      if (Top !== m_top() || Count !== CW'(q.size()) || Empty !== (q.size() == 0) ||
          Full !== (q.size() == DEPTH) || Overflow !== m_ovf || Underflow !== m_unf) begin
        errors++;
        $display("FAIL random[%0d]: top=%h count=%0d e/f/o/u=%b%b%b%b, want %h %0d %b%b%b%b",
                 n, Top, Count, Empty, Full, Overflow, Underflow, m_top(), q.size(),
                 q.size() == 0, q.size() == DEPTH, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Push = 1'b0; Pop = 1'b0; PushData = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_reset_mid();
    test_replace();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- LIFO of instruction addresses for subroutine call/return in the mini processor.
- The writer side (call) pushes the return address, typically the program counter plus 2.
- The reader side (return) pops that address and presents it as the next program-counter load value.
- Sits beside the program counter. Top drives the counter's Initial-style load value when a return is decoded.

Parameters:
- SIZE, 16, address width in bits (matches the program counter width).
- DEPTH, 8, number of stack entries; must be 2 or greater.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Push  input  1  store PushData on top of the stack this cycle
- Pop  input  1  remove the top entry this cycle
- PushData  input  SIZE  return address to store
- Top  output  SIZE  registered copy of the current top entry; 0 when empty
- Count  output  $clog2(DEPTH+1)  number of valid entries
- Empty  output  1  Count==0
- Full  output  1  Count==DEPTH
- Overflow  output  1  sticky; set by a rejected push
- Underflow  output  1  sticky; set by a rejected pop

Behaviour:
- Reset is synchronous, active-high, on clock Clock. Reset has priority over Push and Pop in the same cycle.
- Reset values: Count=0, Top=0, Empty=1, Full=0, Overflow=0, Underflow=0.
- Entry storage is not cleared by reset. Only the pointer and the outputs are reset.
- Reset mid-operation discards all entries. The next push after reset lands at entry 0.
- All outputs are registered. They update on the Clock edge that samples the request, so there is one cycle of latency from request to visible result.
- Empty and Full are derived from the registered Count.
- Operation table, by (Push,Pop) and state:
  - (0,0): hold everything.
  - (1,0), not full: mem[Count] <= PushData; Count+1; Top <= PushData.
  - (1,0), full: ignored; Overflow <= 1. Count, Top and storage unchanged.
  - (0,1), not empty: Count-1. Top <= mem[Count-2] if Count>=2, else Top <= 0.
  - (0,1), empty: ignored; Underflow <= 1.
  - (1,1), not empty (including full): replace the top. mem[Count-1] <= PushData; Count unchanged; Top <= PushData; no flag set.
  - (1,1), empty: the push is performed (Count becomes 1, Top <= PushData). The pop is rejected and Underflow <= 1.
- Overflow and Underflow stay set until Reset.
- Arithmetic: the pointer never wraps. Count saturates at 0 and DEPTH purely through the rejection rules above.
- Top for the pop case is read from storage in the same cycle as the pointer update. Storage has one write port and one asynchronous read port addressed by (Count-2).

Decomposition:
- Shared package holds:
  - RAS_ADDR_W = 16 and RAS_DEPTH = 8 as defaults.
  - A 2-bit op encoding: OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, formed from {Push,Pop}.
- Natural sub-module: stack_regfile.
  - DEPTH x SIZE register array.
  - Write port: WrEn, WrAddr, WrData, all synchronous.
  - Read port: RdAddr, RdData, asynchronous.
  - No reset.
- return_address_stack holds the pointer, the flags, the Top register, and the op decode.

Test Plan:
- Reset, then idle 3 cycles -> Count=0, Top=0, Empty=1, Full=0, Overflow=0, Underflow=0.
- Push 0x0010, 0x0020, 0x0030 on consecutive cycles -> Top=0x0030, Count=3. Then pop three times -> Top goes 0x0020, 0x0010, 0x0000; Empty=1 after the third pop.
- Push 8 values 0x0002 through 0x0010 in steps of 2 -> Full=1, Top=0x0010. A ninth push of 0xFFFF -> Overflow=1, Top stays 0x0010, Count=8. Then push+pop with 0x1234 -> Top=0x1234, Count=8, Full=1.
- From empty, Pop -> Underflow=1, Count=0. Then push+pop with 0x00AA -> Count=1, Top=0x00AA; Underflow remains 1.
- With Count=5, assert Reset together with Push -> Count=0, Top=0, flags cleared. Next push of 0x0042 -> Count=1, Top=0x0042.
- With Count=2 holding [0x0100, 0x0200], push+pop with 0x0300 -> Count=2, Top=0x0300. Then pop -> Top=0x0100.
